game_input_conditioner: RTL and testbench
=========================================

# game_input_conditioner

Synchronises, debounces and edge-detects the four raw board inputs (two slide switches, two push-buttons) before they reach the top-level game state machine and the level drawers. It sits directly upstream of the game top level: the START→LEVEL1 transition consumes `start_press` and the levels consume the clean `left_level`, `right_level` and `jump_press`. All logic runs in the `vga_clock` domain, so no further synchronisation is needed downstream.

## Interface
- `DEBOUNCE_CYCLES`, 250000: input must be stable for this many consecutive cycles before the clean level changes (10 ms at 25 MHz). Must be ≥2.
- `BUTTON_ACTIVE_LOW`, 1: when 1, `jump_button` and `start_button` are inverted at the input (a pressed key reads 0). Switches are always active-high.

Ports:
- `vga_clock` in 1: pixel clock; the only clock.
- `reset` in 1: asynchronous, active-high reset (already decided).
- `left_switch` in 1: raw slide switch, asynchronous.
- `right_switch` in 1: raw slide switch, asynchronous.
- `jump_button` in 1: raw push-button, asynchronous.
- `start_button` in 1: raw push-button, asynchronous.
- `left_level` out 1: debounced switch level.
- `right_level` out 1: debounced switch level.
- `jump_held` out 1: debounced, logical (active-high) jump level.
- `jump_press` out 1: one-cycle pulse on the debounced rising edge of jump.
- `start_press` out 1: one-cycle pulse on the debounced rising edge of start.

## Operation
- Each input is handled by an identical channel:
  - polarity normalisation;
  - 2-FF synchroniser (`s1`, `s2`);
  - debounce counter `cnt`, width `$clog2(DEBOUNCE_CYCLES)`;
  - stable register `stable`;
  - registered rise pulse.
- Per channel, at each clock edge:
  - If `s2 == stable`, then `cnt <= 0`.
  - Else, if `cnt == DEBOUNCE_CYCLES-1`, then `stable <= s2` and `cnt <= 0`.
  - Else `cnt <= cnt+1`.
- Any return of `s2` to `stable` before the count completes clears `cnt`. Glitches shorter than `DEBOUNCE_CYCLES` cycles therefore never change `stable`. The counter never wraps.
- The rise pulse is registered: it is high for exactly one cycle, the same cycle in which `stable` first reads 1.
  - No pulse on the falling edge.
  - No repeat while the input is held.
- Channel state machine, implied by `stable`/`cnt`:
  - IDLE_LOW → COUNT_UP (on `s2=1`) → HIGH (after the count completes) → COUNT_DOWN (on `s2=0`) → IDLE_LOW.
  - An aborted count returns to the originating idle state.
- `left_level`, `right_level` and `jump_held` are the channel `stable` values. `jump_press` and `start_press` are the channel rise pulses.
- Reset, from any state including mid-count:
  - Synchronisers are loaded with the logical-inactive value (0 after normalisation).
  - All `cnt` are cleared.
  - All outputs go to 0.
  - An input already asserted at reset release must complete a full debounce before `stable` rises and a pulse fires. A button held through reset therefore produces exactly one press after release.

## Timing
- Latency: a clean raw transition sampled at edge k appears in `s2` after edge k+1. `stable` and the pulse change after edge k+1+`DEBOUNCE_CYCLES`.
- Release path: the same latency applies to the falling edge, with no pulse.
- Simultaneous activity on different channels is fully independent. Each channel's pulse is generated in its own cycle and may coincide with the others.
- A bounce that lasts exactly `DEBOUNCE_CYCLES-1` cycles is rejected. One that lasts `DEBOUNCE_CYCLES` cycles is accepted.
- Reset deassertion: outputs are valid from the first edge after release. The earliest possible press is `DEBOUNCE_CYCLES+2` edges after release.

## Structure
- Package `game_input_pkg`:
  - `DEFAULT_DEBOUNCE_CYCLES`;
  - channel index enum `{CH_LEFT, CH_RIGHT, CH_JUMP, CH_START}`;
  - `NUM_INPUT_CHANNELS = 4`.
- Sub-module `debounce_channel`:
  - Parameters: `DEBOUNCE_CYCLES`, `ACTIVE_LOW`.
  - Ports: `vga_clock`, `reset`, `raw`, `level`, `rise_pulse`.
  - Instantiated 4× by index.
- Top wrapper: polarity-selection parameters, instantiation and output mapping only.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=8` and `BUTTON_ACTIVE_LOW=1`.
- Reset: hold `reset=1` with random raw inputs. All outputs read 0. After release, with `start_button=1` (idle), there is no pulse for 50 cycles.
- Clean press: drive `start_button` 1→0 at edge k and hold it. `start_press`=1 for exactly one cycle after edge k+9, then 0 while held. Releasing it produces no pulse.
- Bounce rejection: toggle `jump_button` low for 7 cycles, then high, repeated 5 times. `jump_held` stays 0 and `jump_press` never fires. A subsequent 8-cycle low gives `jump_held`=1 plus one pulse.
- Switch level: set `left_switch`=1 at edge k. `left_level` rises after edge k+9. Clear it. `left_level` falls 9 edges later. `right_level` is unaffected throughout.
- Mid-count reset: `jump_button` is low for 5 cycles, then `reset` pulses for 2 cycles while the button stays low. There is no pulse during reset. Exactly one `jump_press` occurs 10 edges after release.
- Simultaneous: `start_button` and `jump_button` go low on the same edge. `start_press` and `jump_press` each pulse once, in the same cycle.

Source files
------------

// File: rtl/game_input_conditioner_pkg.sv
// Shared constants and channel indexing for the board input conditioner.
package game_input_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 250000;
  localparam int unsigned NUM_INPUT_CHANNELS      = 4;

  typedef enum logic [1:0] {
    CH_LEFT  = 2'd0,
    CH_RIGHT = 2'd1,
    CH_JUMP  = 2'd2,
    CH_START = 2'd3
  } input_channel_e;

endpackage

// File: rtl/game_input_conditioner_if.sv
// Raw board inputs and their conditioned counterparts, grouped as one bundle.
interface game_input_conditioner_if;

    logic left_switch;
    logic right_switch;
    logic jump_button;
    logic start_button;

    logic left_level;
    logic right_level;
    logic jump_held;
    logic jump_press;
    logic start_press;

    // Board side: drives raw inputs, observes conditioned outputs.
    modport master (
        output left_switch, right_switch, jump_button, start_button,
        input  left_level, right_level, jump_held, jump_press, start_press
    );

    // Conditioner side.
    modport slave (
        input  left_switch, right_switch, jump_button, start_button,
        output left_level, right_level, jump_held, jump_press, start_press
    );

endinterface

// File: rtl/game_input_conditioner_debounce_channel.sv
// One input channel: polarity fix, 2-FF synchroniser, debounce counter, rise pulse.
module debounce_channel
    import game_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic vga_clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            raw_norm;
    logic            s1_q, s2_q;
    logic            stable_q, stable_d;
    logic            rise_q, rise_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    assign raw_norm = raw ^ ACTIVE_LOW;

    // Counter only runs while the synchronised value disagrees with stable; any
    // agreement before completion clears it, so short glitches never land.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            stable_d = s2_q;
            cnt_d    = '0;
            rise_d   = s2_q;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            s1_q     <= raw_norm;
            s2_q     <= s1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
        end
    end

    assign level      = stable_q;
    assign rise_pulse = rise_q;

endmodule

// File: rtl/game_input_conditioner.sv
// Conditions the four raw board inputs into clean levels and press pulses.
module game_input_conditioner
    import game_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
    input  logic                     vga_clock,
    input  logic                     reset,
    game_input_conditioner_if.slave  bus
);

    logic [NUM_INPUT_CHANNELS-1:0] raw_vec;
    logic [NUM_INPUT_CHANNELS-1:0] level_vec;
    logic [NUM_INPUT_CHANNELS-1:0] rise_vec;
    logic [1:0]                    unused_switch_rise;

    assign raw_vec[CH_LEFT]  = bus.left_switch;
    assign raw_vec[CH_RIGHT] = bus.right_switch;
    assign raw_vec[CH_JUMP]  = bus.jump_button;
    assign raw_vec[CH_START] = bus.start_button;

    for (genvar i = 0; i < NUM_INPUT_CHANNELS; i++) begin : g_ch
        // Only the push-buttons may be wired active-low; switches are always active-high.
        localparam bit IsButton = (i == int'(CH_JUMP)) || (i == int'(CH_START));
        localparam bit ActLow   = IsButton ? BUTTON_ACTIVE_LOW : 1'b0;

        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ActLow)
        ) u_ch (
            .vga_clock  (vga_clock),
            .reset      (reset),
            .raw        (raw_vec[i]),
            .level      (level_vec[i]),
            .rise_pulse (rise_vec[i])
        );
    end

    assign bus.left_level  = level_vec[CH_LEFT];
    assign bus.right_level = level_vec[CH_RIGHT];
    assign bus.jump_held   = level_vec[CH_JUMP];
    assign bus.jump_press  = rise_vec[CH_JUMP];
    assign bus.start_press = rise_vec[CH_START];

    assign unused_switch_rise = {rise_vec[CH_RIGHT], rise_vec[CH_LEFT]};

endmodule

// File: tb/tb_game_input_conditioner.sv
// Directed bench for game_input_conditioner with DEBOUNCE_CYCLES=8, active-low buttons.
module tb_game_input_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    game_input_conditioner_if bus ();

    game_input_conditioner #(
        .DEBOUNCE_CYCLES   (8),
        .BUTTON_ACTIVE_LOW (1'b1)
    ) dut (
        .vga_clock (clk),
        .reset     (rst),
        .bus       (bus)
    );

    typedef struct {
        logic        ls;
        logic        rs;
        logic        jb;
        logic        sb;
        int unsigned hold;
        logic [4:0]  exp;   // {left_level, right_level, jump_held, jump_press, start_press}
    } vec_t;

    vec_t vecs [13];

    int total = 0;
    int bad   = 0;
    int jp_cnt = 0;
    int sp_cnt = 0;
    logic held_seen = 1'b0;

    function automatic logic [4:0] outs();
        return {bus.left_level, bus.right_level, bus.jump_held, bus.jump_press, bus.start_press};
    endfunction

    task automatic check5(input string name, input logic [4:0] got, input logic [4:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input logic ls, input logic rs, input logic jb, input logic sb);
        bus.left_switch  = ls;
        bus.right_switch = rs;
        bus.jump_button  = jb;
        bus.start_button = sb;
    endtask

    // Advance n rising edges, sampling 1 time unit after each to tally pulses.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            jp_cnt += int'(bus.jump_press);
            sp_cnt += int'(bus.start_press);
            held_seen = held_seen | bus.jump_held;
        end
    endtask

    task automatic clear_tally();
        jp_cnt    = 0;
        sp_cnt    = 0;
        held_seen = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 20, 5'b00000};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1,  9, 5'b00000};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1,  1, 5'b10000};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 10, 5'b11000};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 10, 5'b01000};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 10, 5'b00000};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 10, 5'b00001};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0,  1, 5'b00000};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 12, 5'b00000};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 10, 5'b00110};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1,  1, 5'b00100};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1,  9, 5'b00100};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1,  1, 5'b00000};

        // Reset held with random raw inputs: everything stays low.
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            run(1);
            check5("reset_outs", outs(), 5'b00000);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        run(1);
        rst = 1'b0;
        clear_tally();
        run(50);
        check_int("idle_jump_pulses", jp_cnt, 0);
        check_int("idle_start_pulses", sp_cnt, 0);
        check5("idle_outs", outs(), 5'b00000);

        // Table-driven levels, clean presses and releases.
        for (int v = 0; v < 13; v++) begin
            drive(vecs[v].ls, vecs[v].rs, vecs[v].jb, vecs[v].sb);
            run(int'(vecs[v].hold));
            check5($sformatf("vec%0d", v), outs(), vecs[v].exp);
        end

        // Bounces of 7 low cycles are rejected.
        clear_tally();
        for (int r = 0; r < 5; r++) begin
            bus.jump_button = 1'b0;
            run(7);
            bus.jump_button = 1'b1;
            run(3);
        end
        check_int("bounce7_pulses", jp_cnt, 0);
        check_int("bounce7_held", int'(held_seen), 0);

        // An 8-cycle low is accepted with one pulse.
        clear_tally();
        bus.jump_button = 1'b0;
        run(8);
        bus.jump_button = 1'b1;
        run(1);
        check5("low8_before_accept", outs(), 5'b00000);
        run(1);
        check5("low8_accept", outs(), 5'b00110);
        run(20);
        check_int("low8_pulses", jp_cnt, 1);
        check5("low8_settled", outs(), 5'b00000);

        // Reset in the middle of a count; button stays pressed throughout.
        clear_tally();
        bus.jump_button = 1'b0;
        run(5);
        rst = 1'b1;
        run(1);
        check5("midreset_1", outs(), 5'b00000);
        run(1);
        check5("midreset_2", outs(), 5'b00000);
        rst = 1'b0;
        run(9);
        check_int("midreset_early_pulses", jp_cnt, 0);
        check5("midreset_edge9", outs(), 5'b00000);
        run(1);
        check5("midreset_edge10", outs(), 5'b00110);
        run(5);
        check_int("midreset_pulses", jp_cnt, 1);
        bus.jump_button = 1'b1;
        run(12);
        check5("midreset_released", outs(), 5'b00000);

        // Simultaneous jump and start presses pulse together.
        clear_tally();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        run(9);
        check5("simul_edge9", outs(), 5'b00000);
        run(1);
        check5("simul_edge10", outs(), 5'b00111);
        run(1);
        check5("simul_edge11", outs(), 5'b00100);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        run(12);
        check5("simul_released", outs(), 5'b00000);
        check_int("simul_jump_pulses", jp_cnt, 1);
        check_int("simul_start_pulses", sp_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
